branch_target_predictor: RTL and testbench

Parametrised successor to the fixed 1-bit branch predictor used by hazard detection. It provides a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters, and an in-flight prediction FIFO that pairs each fetched branch with its resolution in WB. It also provides mispredict detection with a redirect PC, plus saturating performance counters. It sits beside hazard detection: fetch (IF) looks it up and WB resolves it.

---
 rtl/branch_target_predictor_pkg.sv | 29 ++
 rtl/branch_inflight_fifo.sv | 56 +++++
 rtl/branch_target_predictor.sv | 138 +++++++++++++
 tb/tb_branch_target_predictor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_target_predictor_pkg.sv
// ============================================================================
// branch_target_predictor_pkg : shared types and counter constants for the BTB
// Rev 1.0
// ============================================================================
`default_nettype none

package branch_target_predictor_pkg;

    localparam int PC_WIDTH = 16;

    typedef logic [PC_WIDTH-1:0] lc3b_word;

    // One in-flight prediction: direction plus the next-fetch PC that was used
    typedef struct packed {
        logic     taken;
        lc3b_word target;
    } lc3b_pred_t;

    function automatic int ctr_weak_taken(input int width);
        return 1 << (width - 1);
    endfunction

    function automatic int ctr_weak_not_taken(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_inflight_fifo.sv
// ============================================================================
// branch_inflight_fifo : circular FIFO of unresolved predictions, with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_inflight_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot this edge, so a full FIFO can still accept a push
    assign do_push = push && (!full || do_pop);
    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/branch_target_predictor.sv
// ============================================================================
// branch_target_predictor : direct-mapped BTB with direction counters,
// in-flight prediction FIFO, mispredict detection and perf counters
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int NUM_ADDR_BITS  = 5,
    parameter int CTR_WIDTH      = 2,
    parameter int INFLIGHT_DEPTH = 4,
    parameter int PERF_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           lookup_pc,
    input  logic                  lookup_is_br,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [15:0]           pred_target,
    output logic                  inflight_full,
    output logic                  branch_in_flight,
    input  logic                  resolve_valid,
    input  logic [15:0]           resolve_pc,
    input  logic                  resolve_taken,
    input  logic [15:0]           resolve_target,
    output logic                  mispredict,
    output logic [15:0]           redirect_pc,
    output logic                  protocol_err,
    output logic [PERF_WIDTH-1:0] branch_count,
    output logic [PERF_WIDTH-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << NUM_ADDR_BITS;
    localparam int TAG_W   = PC_WIDTH - NUM_ADDR_BITS - 1;
    localparam logic [CTR_WIDTH-1:0] CTR_WT  = CTR_WIDTH'(ctr_weak_taken(CTR_WIDTH));
    localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WIDTH'(ctr_weak_not_taken(CTR_WIDTH));
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

    logic                 valid_q  [ENTRIES];
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    lc3b_word             target_q [ENTRIES];
    logic [CTR_WIDTH-1:0] ctr_q    [ENTRIES];

    logic [NUM_ADDR_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]         lk_tag;
    logic [NUM_ADDR_BITS-1:0] rs_idx;
    logic [TAG_W-1:0]         rs_tag;
    logic                     rs_hit;
    logic [CTR_WIDTH-1:0]     rs_ctr;

    lc3b_pred_t push_pred;
    lc3b_pred_t head_pred;
    logic       fifo_empty;
    logic       exp_taken;

    assign lk_idx = lookup_pc[NUM_ADDR_BITS:1];
    assign lk_tag = lookup_pc[15:NUM_ADDR_BITS+1];
    assign rs_idx = resolve_pc[NUM_ADDR_BITS:1];
    assign rs_tag = resolve_pc[15:NUM_ADDR_BITS+1];

    assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = pred_hit && ctr_q[lk_idx][CTR_WIDTH-1];
    assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + 16'd2;

    assign push_pred.taken  = pred_taken;
    assign push_pred.target = pred_target;

    branch_inflight_fifo #(
        .DEPTH (INFLIGHT_DEPTH),
        .WIDTH ($bits(lc3b_pred_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (mispredict),
        .push      (lookup_is_br),
        .pop       (resolve_valid),
        .push_data (push_pred),
        .head_data (head_pred),
        .empty     (fifo_empty),
        .full      (inflight_full)
    );

    assign branch_in_flight = !fifo_empty;

    // An unmatched resolve is judged against an implicit not-taken prediction
    assign exp_taken   = !fifo_empty && head_pred.taken;
    assign mispredict  = resolve_valid &&
                         ((exp_taken != resolve_taken) ||
                          (exp_taken && resolve_taken && (head_pred.target != resolve_target)));
    assign redirect_pc = resolve_taken ? resolve_target : resolve_pc + 16'd2;

    assign rs_hit = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
    assign rs_ctr = ctr_q[rs_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (resolve_valid) begin
            if (resolve_taken) begin
                valid_q[rs_idx]  <= 1'b1;
                tag_q[rs_idx]    <= rs_tag;
                target_q[rs_idx] <= resolve_target;
                if (!rs_hit)
                    ctr_q[rs_idx] <= CTR_WT;
                else if (rs_ctr != CTR_MAX)
                    ctr_q[rs_idx] <= rs_ctr + 1'b1;
            end else if (rs_hit && (rs_ctr != '0)) begin
                ctr_q[rs_idx] <= rs_ctr - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            protocol_err     <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve_valid && fifo_empty)
                protocol_err <= 1'b1;
            if (resolve_valid && (branch_count != '1))
                branch_count <= branch_count + 1'b1;
            if (mispredict && (mispredict_count != '1))
                mispredict_count <= mispredict_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
// ============================================================================
// tb_branch_target_predictor : directed self-checking bench for the BTB
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] lookup_pc;
    logic        lookup_is_br;
    logic        pred_hit;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        inflight_full;
    logic        branch_in_flight;
    logic        resolve_valid;
    logic [15:0] resolve_pc;
    logic        resolve_taken;
    logic [15:0] resolve_target;
    logic        mispredict;
    logic [15:0] redirect_pc;
    logic        protocol_err;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int n_cmp = 0;
    int n_bad = 0;

    branch_target_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lookup_pc        (lookup_pc),
        .lookup_is_br     (lookup_is_br),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .inflight_full    (inflight_full),
        .branch_in_flight (branch_in_flight),
        .resolve_valid    (resolve_valid),
        .resolve_pc       (resolve_pc),
        .resolve_taken    (resolve_taken),
        .resolve_target   (resolve_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .protocol_err     (protocol_err),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [15:0] pc, input logic br);
        lookup_pc    = pc;
        lookup_is_br = br;
        #1;
    endtask

    task automatic res(input logic v, input logic [15:0] pc, input logic t, input logic [15:0] tg);
        resolve_valid  = v;
        resolve_pc     = pc;
        resolve_taken  = t;
        resolve_target = tg;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        lookup_pc = 16'h0; lookup_is_br = 1'b0;
        resolve_valid = 1'b0; resolve_pc = 16'h0; resolve_taken = 1'b0; resolve_target = 16'h0;
        #12 rst_n = 1'b1;

        // reset state
        check("rst_hit", pred_hit, 0);
        check("rst_taken", pred_taken, 0);
        check("rst_mispredict", mispredict, 0);
        check("rst_full", inflight_full, 0);
        check("rst_inflight", branch_in_flight, 0);
        check("rst_perr", protocol_err, 0);
        check("rst_bcount", branch_count, 0);
        tick;

        // cold lookup of a branch
        look(16'h3000, 1);
        check("t1_hit", pred_hit, 0);
        check("t1_taken", pred_taken, 0);
        check("t1_target", pred_target, 16'h3002);
        tick;
        look(16'h3000, 0);
        check("t1_inflight", branch_in_flight, 1);

        // first taken resolve: mispredict and allocate
        res(1, 16'h3000, 1, 16'h3040);
        check("t2_mispredict", mispredict, 1);
        check("t2_redirect", redirect_pc, 16'h3040);
        tick;
        res(0, 16'h0, 0, 16'h0);
        check("t2_flushed", branch_in_flight, 0);
        check("t2_bcount", branch_count, 1);
        check("t2_mcount", mispredict_count, 1);
        check("t2_hit", pred_hit, 1);
        check("t2_taken", pred_taken, 1);
        check("t2_target", pred_target, 16'h3040);

        // train counter to 3 with a correctly predicted taken branch
        look(16'h3000, 1);
        tick;
        look(16'h3000, 0);
        res(1, 16'h3000, 1, 16'h3040);
        check("t3_no_mispredict", mispredict, 0);
        tick;
        res(0, 16'h0, 0, 16'h0);
        look(16'h3000, 1);
        tick;
        look(16'h3000, 0);
        // four not-taken pulses: counter 2,1,0,0
        for (int k = 0; k < 4; k++) begin
            res(1, 16'h3000, 0, 16'h0);
            check($sformatf("t3_mispredict_%0d", k), mispredict, (k == 0) ? 1 : 0);
            if (k == 0) check("t3_redirect", redirect_pc, 16'h3002);
            tick;
            res(0, 16'h0, 0, 16'h0);
            check($sformatf("t3_taken_%0d", k), pred_taken, (k == 0) ? 1 : 0);
        end
        check("t3_bcount", branch_count, 6);
        check("t3_mcount", mispredict_count, 2);
        check("t3_perr", protocol_err, 1);
        // counter climbs back from saturated zero
        res(1, 16'h3000, 1, 16'h3040);
        tick;
        res(0, 16'h0, 0, 16'h0);
        check("t3_ctr1_hit", pred_hit, 1);
        check("t3_ctr1_taken", pred_taken, 0);
        check("t3_ctr1_target", pred_target, 16'h3002);
        res(1, 16'h3000, 1, 16'h3040);
        tick;
        res(0, 16'h0, 0, 16'h0);
        check("t3_ctr2_taken", pred_taken, 1);

        // asynchronous reset mid-cycle with state present
        look(16'h3000, 1);
        tick;
        look(16'h3000, 0);
        check("t6_pre_inflight", branch_in_flight, 1);
        #3 rst_n = 1'b0;
        #1;
        check("t6_async_hit", pred_hit, 0);
        check("t6_async_inflight", branch_in_flight, 0);
        check("t6_async_perr", protocol_err, 0);
        check("t6_async_bcount", branch_count, 0);
        check("t6_async_mcount", mispredict_count, 0);
        #2 rst_n = 1'b1;
        tick;

        // fill FIFO, drop fifth, push+pop while full
        for (int i = 0; i < 4; i++) begin
            look(16'h3000 + 16'(2 * i), 1);
            tick;
        end
        look(16'h3008, 1);
        check("t4_full", inflight_full, 1);
        tick;
        check("t4_full_after_drop", inflight_full, 1);
        look(16'h300A, 1);
        res(1, 16'h3000, 0, 16'h0);
        check("t4_pushpop_mispredict", mispredict, 0);
        tick;
        look(16'h0, 0);
        res(0, 16'h0, 0, 16'h0);
        check("t4_still_full", inflight_full, 1);
        for (int i = 1; i < 4; i++) begin
            res(1, 16'h3000 + 16'(2 * i), 0, 16'h0);
            check($sformatf("t4_drain_%0d", i), mispredict, 0);
            tick;
        end
        res(1, 16'h300A, 0, 16'h0);
        check("t4_drain_last", mispredict, 0);
        tick;
        res(0, 16'h0, 0, 16'h0);
        check("t4_empty", branch_in_flight, 0);
        check("t4_perr", protocol_err, 0);
        check("t4_bcount", branch_count, 5);
        check("t4_mcount", mispredict_count, 0);

        // aliasing on index 0
        res(1, 16'h3000, 1, 16'h3100);
        tick;
        res(0, 16'h0, 0, 16'h0);
        look(16'h3000, 0);
        check("t5_hit_3000", pred_hit, 1);
        check("t5_target_3000", pred_target, 16'h3100);
        res(1, 16'h3040, 1, 16'h3200);
        tick;
        res(0, 16'h0, 0, 16'h0);
        check("t5_evicted", pred_hit, 0);
        look(16'h3040, 0);
        check("t5_hit_3040", pred_hit, 1);
        check("t5_target_3040", pred_target, 16'h3200);
        // same-cycle update is not bypassed to the lookup
        look(16'h3000, 0);
        res(1, 16'h3000, 1, 16'h3300);
        check("t5_no_bypass", pred_hit, 0);
        tick;
        res(0, 16'h0, 0, 16'h0);
        check("t5_after_write_hit", pred_hit, 1);
        check("t5_after_write_target", pred_target, 16'h3300);
        check("t6_perr_sticky", protocol_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
